// File: rtl/sram_loader_pkg.sv
// Shared types, header field positions and width helpers for the SRAM preload loader.
package sram_loader_pkg;

  typedef enum logic [3:0] {
    OP_LOAD = 4'd0,
    OP_END  = 4'd1
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_DATA,
    ST_DONE
  } state_e;

  localparam int OPC_HI  = 31;
  localparam int OPC_LO  = 28;
  localparam int REG_HI  = 27;
  localparam int REG_LO  = 24;
  localparam int MODE_B  = 23;
  localparam int BASE_HI = 22;
  localparam int BASE_LO = 19;

  function automatic int len_w(input int addr_w, input int num_banks);
    return addr_w + $clog2(num_banks) + 1;
  endfunction

  // Index width that never collapses to zero for single-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_preload_loader_if.sv
// Load stream and SRAM write bus of the preload loader.
interface sram_preload_loader_if
  import sram_loader_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10,
  parameter int NUM_BANKS   = 4,
  parameter int NUM_REGIONS = 8
);
  localparam int RW = idx_w(NUM_REGIONS);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [RW-1:0]     wr_region;
  logic [NUM_BANKS-1:0] wr_bank_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_region, wr_bank_en, wr_addr, wr_data
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, wr_region, wr_bank_en, wr_addr, wr_data
  );
endinterface

// File: rtl/sram_preload_loader_addr_gen.sv
// Bank/address generator for beat k of a segment, contiguous or bank-interleaved.
module loader_addr_gen
  import sram_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int NUM_BANKS = 4,
  parameter int LEN_W     = len_w(ADDR_W, NUM_BANKS),
  parameter int BW        = idx_w(NUM_BANKS)
) (
  input  logic              mode,
  input  logic [BW-1:0]     base,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  k,
  output logic [BW-1:0]     bank,
  output logic [ADDR_W-1:0] addr,
  output logic              ovf
);
  localparam int SUM_W  = LEN_W + 1;
  localparam int FULL_W = LEN_W + 2;
  localparam int LOG_NB = $clog2(NUM_BANKS);

  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  row;
  logic [FULL_W-1:0] full;

  // Interleaved beats walk banks first; the row advances each time the bank wraps.
  assign sum  = SUM_W'(base) + SUM_W'(k);
  assign row  = sum >> LOG_NB;
  assign full = FULL_W'(start_addr) + FULL_W'(mode ? row : SUM_W'(k));
  assign bank = mode ? BW'(sum & SUM_W'(NUM_BANKS - 1)) : base;
  assign addr = full[ADDR_W-1:0];
  assign ovf  = |full[FULL_W-1:ADDR_W];
endmodule

// File: rtl/sram_preload_loader.sv
// Parses a header-framed load stream and scatters its payload into banked SRAM regions.
module sram_preload_loader
  import sram_loader_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10,
  parameter int NUM_BANKS   = 4,
  parameter int NUM_REGIONS = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  sram_preload_loader_if.slave bus,
  output logic busy,
  output logic load_done,
  output logic err,
  output logic core_go
);
  localparam int LEN_W = len_w(ADDR_W, NUM_BANKS);
  localparam int BW    = idx_w(NUM_BANKS);
  localparam int RW    = idx_w(NUM_REGIONS);

  state_e state, nxt;

  logic [RW-1:0]     region_q;
  logic              mode_q;
  logic [BW-1:0]     base_q;
  logic [ADDR_W-1:0] start_q;
  logic [LEN_W-1:0]  len_q, k_q;
  logic              seg_ovf;

  logic [NUM_BANKS-1:0] wr_bank_en_q;
  logic [RW-1:0]        wr_region_q;
  logic [ADDR_W-1:0]    wr_addr_q;
  logic [DATA_W-1:0]    wr_data_q;

  logic rdy, fire, hdr_lat, len_lat, beat, end_hit, hdr_err, sess_start;

  logic [3:0]        hdr_opc, hdr_region, hdr_base;
  logic [LEN_W-1:0]  len_in;
  logic              hdr_ok;
  logic [BW-1:0]     ag_bank;
  logic [ADDR_W-1:0] ag_addr;
  logic              ag_ovf;

  assign hdr_opc    = bus.in_data[OPC_HI:OPC_LO];
  assign hdr_region = bus.in_data[REG_HI:REG_LO];
  assign hdr_base   = bus.in_data[BASE_HI:BASE_LO];
  assign len_in     = bus.in_data[LEN_W-1:0];
  assign hdr_ok     = (int'(hdr_region) < NUM_REGIONS) && (int'(hdr_base) < NUM_BANKS);
  assign fire       = bus.in_valid && rdy;

  loader_addr_gen #(
    .ADDR_W(ADDR_W), .NUM_BANKS(NUM_BANKS), .LEN_W(LEN_W), .BW(BW)
  ) u_addr_gen (
    .mode(mode_q), .base(base_q), .start_addr(start_q), .k(k_q),
    .bank(ag_bank), .addr(ag_addr), .ovf(ag_ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt        = state;
    rdy        = 1'b0;
    busy       = 1'b0;
    hdr_lat    = 1'b0;
    len_lat    = 1'b0;
    beat       = 1'b0;
    end_hit    = 1'b0;
    hdr_err    = 1'b0;
    sess_start = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          sess_start = 1'b1;
          nxt        = ST_HDR0;
        end
      end
      ST_HDR0: begin
        rdy  = 1'b1;
        busy = 1'b1;
        if (fire) begin
          if (hdr_opc == OP_LOAD && hdr_ok) begin
            hdr_lat = 1'b1;
            nxt     = ST_HDR1;
          end else if (hdr_opc == OP_END) begin
            end_hit = 1'b1;
            nxt     = ST_DONE;
          end else begin
            hdr_err = 1'b1;
            nxt     = ST_DONE;
          end
        end
      end
      ST_HDR1: begin
        rdy  = 1'b1;
        busy = 1'b1;
        if (fire) begin
          len_lat = 1'b1;
          nxt     = (len_in == '0) ? ST_HDR0 : ST_DATA;
        end
      end
      ST_DATA: begin
        rdy  = 1'b1;
        busy = 1'b1;
        if (fire) begin
          beat = 1'b1;
          if (k_q == len_q - LEN_W'(1)) nxt = ST_HDR0;
        end
      end
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      region_q     <= '0;
      mode_q       <= 1'b0;
      base_q       <= '0;
      start_q      <= '0;
      len_q        <= '0;
      k_q          <= '0;
      seg_ovf      <= 1'b0;
      wr_bank_en_q <= '0;
      wr_region_q  <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      load_done    <= 1'b0;
      err          <= 1'b0;
      core_go      <= 1'b0;
    end else begin
      core_go      <= 1'b0;
      wr_bank_en_q <= '0;
      if (sess_start) begin
        err       <= 1'b0;
        load_done <= 1'b0;
      end
      if (hdr_lat) begin
        region_q <= hdr_region[RW-1:0];
        mode_q   <= bus.in_data[MODE_B];
        base_q   <= hdr_base[BW-1:0];
        start_q  <= bus.in_data[ADDR_W-1:0];
      end
      if (len_lat) begin
        len_q   <= len_in;
        k_q     <= '0;
        seg_ovf <= 1'b0;
      end
      if (beat) begin
        k_q <= k_q + LEN_W'(1);
        // Once a segment runs off the end of the bank, the rest of it is dropped.
        if (ag_ovf || seg_ovf) begin
          seg_ovf <= 1'b1;
          err     <= 1'b1;
        end else begin
          wr_bank_en_q <= NUM_BANKS'(1) << ag_bank;
          wr_region_q  <= region_q;
          wr_addr_q    <= ag_addr;
          wr_data_q    <= bus.in_data;
        end
      end
      if (end_hit) begin
        load_done <= 1'b1;
        core_go   <= ~err;
      end
      if (hdr_err) begin
        load_done <= 1'b1;
        err       <= 1'b1;
      end
    end
  end

  assign bus.in_ready   = rdy;
  assign bus.wr_bank_en = wr_bank_en_q;
  assign bus.wr_region  = wr_region_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
endmodule

// File: tb/tb_sram_preload_loader.sv
// Randomized bench for sram_preload_loader with an arithmetic reference of the write pattern.
module tb_sram_preload_loader;
  localparam int DATA_W = 32, ADDR_W = 10, NB = 4, NR = 8;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic busy, load_done, err, core_go;
  int   n_chk = 0, n_fail = 0;
  bit   exp_err;

  sram_preload_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_BANKS(NB), .NUM_REGIONS(NR)) bus ();

  sram_preload_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_BANKS(NB), .NUM_REGIONS(NR)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .busy(busy), .load_done(load_done), .err(err), .core_go(core_go)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdy"}, bus.in_ready, 0);
    chk({tag, "_ben"}, bus.wr_bank_en, 0);
    chk({tag, "_reg"}, bus.wr_region, 0);
    chk({tag, "_adr"}, bus.wr_addr, 0);
    chk({tag, "_dat"}, bus.wr_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, load_done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_go"}, core_go, 0);
  endtask

  // Present one word and wait (bounded) for it to be taken; then check the write it must cause.
  task automatic push(input string tag, input logic [31:0] w, input bit we,
                      input int bank, input int addr, input int region);
    bit ok = 0;
    bit rdy;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    for (int t = 0; t < 8 && !ok; t++) begin
      rdy = bus.in_ready;
      tick();
      if (rdy) ok = 1;
    end
    bus.in_valid = 1'b0;
    chk({tag, "_acc"}, ok, 1);
    if (we) begin
      chk({tag, "_ben"}, bus.wr_bank_en, 64'(1) << bank);
      chk({tag, "_adr"}, bus.wr_addr, 64'(addr));
      chk({tag, "_dat"}, bus.wr_data, 64'(w));
      chk({tag, "_reg"}, bus.wr_region, 64'(region));
    end else begin
      chk({tag, "_nowr"}, bus.wr_bank_en, 0);
    end
  endtask

  // Stall cycles; a start pulse here lands while busy and must be ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b0;
      start = ($urandom_range(0, 3) == 0);
      tick();
      start = 1'b0;
      chk("stall_nowr", bus.wr_bank_en, 0);
      chk("stall_busy", busy, 1);
    end
  endtask

  task automatic begin_session();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_err = 0;
    chk("start_busy", busy, 1);
    chk("start_rdy", bus.in_ready, 1);
    chk("start_err", err, 0);
    chk("start_done", load_done, 0);
  endtask

  task automatic end_session();
    push("end", 32'h1000_0000, 0, 0, 0, 0);
    chk("end_done", load_done, 1);
    chk("end_go", core_go, !exp_err);
    chk("end_err", err, exp_err);
    chk("end_busy", busy, 0);
    tick();
    chk("end_go_pulse", core_go, 0);
    chk("end_hold", load_done, 1);
  endtask

  // Reference: each beat's bank/address follows directly from the header fields and k.
  // stall: 0 none, 1 one idle cycle per beat, 2 random. abort_at >= 0 asserts reset on that beat.
  task automatic seg(input int region, input int mode, input int base, input int st,
                     input int len, input int stall, input int abort_at);
    logic [31:0] h;
    bit ovf = 0;
    int b, a;
    logic [31:0] d;
    h = 32'((region << 24) | (mode << 23) | (base << 19) | st);
    push("hdr0", h, 0, 0, 0, 0);
    push("hdr1", 32'(len), 0, 0, 0, 0);
    for (int k = 0; k < len; k++) begin
      if (mode != 0) begin
        b = (base + k) % NB;
        a = st + (base + k) / NB;
      end else begin
        b = base;
        a = st + k;
      end
      if (a > (1 << ADDR_W) - 1) ovf = 1;
      if (ovf) exp_err = 1;
      d = $urandom;
      if (k == abort_at) begin
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        reset = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk_all_zero("rst_mid");
        reset = 1'b0;
        exp_err = 0;
        return;
      end
      push("beat", d, !ovf, b, a, region);
      if (stall == 1) idle(1);
      else if (stall == 2) idle($urandom_range(0, 2));
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    exp_err = 0;
    tick();
    tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();
    chk_all_zero("idle");

    // Contiguous: bank 2, addrs 5..7
    begin_session();
    seg(0, 0, 2, 5, 3, 0, -1);
    end_session();

    // Interleaved: banks 3,0,1,2,3,0 at addrs 0,1,1,1,1,2
    begin_session();
    seg(4, 1, 3, 0, 6, 0, -1);
    end_session();

    // Backpressure
    begin_session();
    seg(1, 0, 0, 100, 4, 1, -1);
    end_session();

    // Overflow past the top of the bank
    begin_session();
    seg(2, 0, 1, 1022, 4, 0, -1);
    end_session();

    // Reset on the third beat, then a clean session
    begin_session();
    seg(3, 1, 1, 10, 8, 0, 2);
    chk("post_rst_busy", busy, 0);
    begin_session();
    seg(3, 1, 1, 10, 8, 0, -1);
    end_session();

    // Bad opcode
    begin_session();
    push("bad_opc", 32'h7000_0000, 0, 0, 0, 0);
    chk("bad_opc_err", err, 1);
    chk("bad_opc_busy", busy, 0);
    chk("bad_opc_rdy", bus.in_ready, 0);
    chk("bad_opc_go", core_go, 0);
    tick();
    chk("bad_opc_hold", err, 1);
    chk("bad_opc_go2", core_go, 0);

    // Region out of range
    begin_session();
    push("bad_reg", 32'h0900_0000, 0, 0, 0, 0);
    chk("bad_reg_err", err, 1);
    chk("bad_reg_go", core_go, 0);

    // Empty segment falls straight back to header parsing
    begin_session();
    seg(5, 0, 0, 0, 0, 0, -1);
    seg(6, 1, 2, 7, 2, 0, -1);
    end_session();

    for (int i = 0; i < 12; i++) begin
      begin_session();
      for (int s = 0; s < $urandom_range(1, 3); s++)
        seg($urandom_range(0, NR - 1), $urandom_range(0, 1), $urandom_range(0, NB - 1),
            $urandom_range(0, 1023), $urandom_range(0, 12), 2, -1);
      end_session();
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/sram_preload_loader.md
SRAM_PRELOAD_LOADER -- requirements
Module: sram_preload_loader

Interface
REQ-001 Parameter DATA_W, default 32: stream and SRAM word width; SHALL be at least 32.
REQ-002 Parameter ADDR_W, default 10: per-bank SRAM address width.
REQ-003 Parameter NUM_BANKS, default 4: banks per region; SHALL be a power of two, 1..16.
REQ-004 Parameter NUM_REGIONS, default 8: number of SRAM regions (FV, FV pointer, neighbor info, packet, neighbor, ...).
REQ-005 clk  input  1  sole clock, all logic on posedge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  begin a load session; sampled only in IDLE or DONE.
REQ-008 in_valid / in_data  input  1 / DATA_W  load stream beat.
REQ-009 in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-010 wr_region  output  clog2(NUM_REGIONS)  target region index.
REQ-011 wr_bank_en  output  NUM_BANKS  one-hot bank write enable.
REQ-012 wr_addr / wr_data  output  ADDR_W / DATA_W  write address and data.
REQ-013 busy, load_done, err  output  1 each  session active, session finished, sticky error.
REQ-014 core_go  output  1  one-cycle pulse releasing the compute core.

Function
REQ-015 FSM states IDLE, HDR0, HDR1, DATA, DONE; in_ready SHALL be 1 exactly in HDR0, HDR1, DATA.
REQ-016 IDLE/DONE + start -> HDR0; busy=1 in HDR0/HDR1/DATA; err and load_done clear on start.
REQ-017 HDR0 word: [31:28] opcode (0 LOAD, 1 END), [27:24] region, [23] mode (0 contiguous, 1 interleaved), [22:19] base bank, [ADDR_W-1:0] start address.
REQ-018 LOAD -> HDR1; END -> DONE with load_done=1 and core_go pulsed in the DONE-entry cycle only if err=0.
REQ-019 Other opcode, region >= NUM_REGIONS, or base bank >= NUM_BANKS: set err, enter DONE, no core_go.
REQ-020 HDR1 word [LEN_W-1:0] = beat count L, LEN_W = ADDR_W+clog2(NUM_BANKS)+1; L=0 -> HDR0 with no writes, else DATA.
REQ-021 Beat k (0..L-1), contiguous: bank = base, addr = start+k.
REQ-022 Beat k, interleaved: bank = (base+k) mod NUM_BANKS, addr = start + floor((base+k)/NUM_BANKS).
REQ-023 Write outputs SHALL be registered: one write exactly one cycle after each accepted DATA beat; wr_bank_en=0 otherwise.
REQ-024 Computed address exceeding 2^ADDR_W-1: that write and all later writes of the segment suppressed, err set, remaining beats still consumed.
REQ-025 After beat L-1 accepted -> HDR0; stalls (in_valid=0) SHALL not advance k or issue writes.
REQ-026 start while busy SHALL be ignored; DONE holds until the next start.

Reset
REQ-027 reset SHALL force IDLE and drive in_ready, wr_bank_en, wr_region, wr_addr, wr_data, busy, load_done, err, core_go to 0 in the following cycle.
REQ-028 Reset mid-segment SHALL suppress any write pending from the reset cycle; no partial header state persists.

Structure
REQ-029 Package sram_loader_pkg SHALL hold the opcode enum, FSM state enum, HDR0 field bit positions and the LEN_W function.
REQ-030 Sub-module loader_addr_gen SHALL compute bank/addr/overflow from mode, base, start and k; the FSM lives in sram_preload_loader.

Verification
REQ-031 Contiguous: LOAD region 0 bank 2 start 5, L=3, data A,B,C then END -> bank_en 4'b0100 at addr 5,6,7; core_go one pulse.
REQ-032 Interleaved: region 4 base 3 start 0, L=6 -> banks 3,0,1,2,3,0 at addrs 0,1,1,1,1,2.
REQ-033 Backpressure: in_valid toggled every other cycle during L=4 -> exactly 4 writes, each one cycle after acceptance.
REQ-034 Overflow: ADDR_W=10, contiguous start 1022, L=4 -> writes at 1022,1023 only; err=1; END gives load_done=1, core_go=0.
REQ-035 Reset asserted on third DATA beat of L=8 -> next cycle all outputs 0, state IDLE; new session from start loads correctly.
REQ-036 Opcode 7 in HDR0 -> err=1, DONE, no writes, no core_go; L=0 segment -> no writes, returns to HDR0.
